hv_scan_reg_bist_rsp: RTL

Responder side of the HV scan-register BIST handshake. It sits beside the HV scan register file. On each BIST request it reads the next scan register together with its stored complement copy and checks them against each other. It then returns a one-cycle acknowledge carrying a pass/fail flag, and keeps a failure count plus the address of the first failing register for debug readout.

---
 rtl/hv_scan_reg_bist_rsp.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/hv_scan_reg_bist_rsp.sv
// -----------------------------------------------------------------------------
// hv_scan_reg_bist_rsp
//
// Responder side of the HV scan-register BIST handshake. Each BIST request
// reads the next scan register and its stored complement copy and checks that
// they are exact bitwise complements. It answers with a one-cycle acknowledge
// carrying a pass/fail flag. A saturating failure count and the address of the
// first failing register are kept for debug readout.
//
// Handshake: i_bist_scan_reg_req is a level. It is accepted in IDLE and answered
// by exactly one o_scan_reg_bist_ack pulse. After that the responder waits for
// req to be seen low before it accepts another request. o_scan_reg_bist_err is
// meaningful only while ack is high and is 0 otherwise.
//
// Ports:
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_bist_en               BIST window; low clears all run state
//   i_bist_scan_reg_req     request level from the BIST initiator
//   o_scan_reg_bist_ack     one-cycle acknowledge
//   o_scan_reg_bist_err     result of the acked request (1 = fail)
//   o_scan_reg_rd_en        one-cycle read strobe to the scan register file
//   o_scan_reg_rd_addr      read address, held after the strobe
//   i_scan_reg_rd_data      register value, valid the cycle after rd_en
//   i_scan_reg_rd_chk       stored complement copy, valid with rd_data
//   o_err_cnt               saturating failure count for the current run
//   o_fail_addr             address of the first failure in the current run
//   o_fail_vld              o_fail_addr holds a captured failure
// -----------------------------------------------------------------------------
module hv_scan_reg_bist_rsp #(
    parameter int SCAN_REG_NUM = 8,
    parameter int REG_DW       = 8,
    parameter int ADDR_W       = $clog2(SCAN_REG_NUM + 1),
    parameter int ERR_CNT_W    = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_bist_en,
    input  logic                 i_bist_scan_reg_req,
    output logic                 o_scan_reg_bist_ack,
    output logic                 o_scan_reg_bist_err,
    output logic                 o_scan_reg_rd_en,
    output logic [ADDR_W-1:0]    o_scan_reg_rd_addr,
    input  logic [REG_DW-1:0]    i_scan_reg_rd_data,
    input  logic [REG_DW-1:0]    i_scan_reg_rd_chk,
    output logic [ERR_CNT_W-1:0] o_err_cnt,
    output logic [ADDR_W-1:0]    o_fail_addr,
    output logic                 o_fail_vld
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD       = 3'd1,
        ST_CHK      = 3'd2,
        ST_ACK      = 3'd3,
        ST_WAIT_LOW = 3'd4
    } state_t;

    localparam logic [ADDR_W-1:0]    LP_IDX_END = ADDR_W'(SCAN_REG_NUM);
    localparam logic [ERR_CNT_W-1:0] LP_CNT_MAX = {ERR_CNT_W{1'b1}};

    state_t                 r_state;
    logic [ADDR_W-1:0]      r_idx;
    logic                   r_mis;      // result carried from CHK (or out-of-range) to ACK
    logic                   r_oor;      // current request is the out-of-range one
    logic                   r_ack;
    logic                   r_err;
    logic                   r_rd_en;
    logic [ADDR_W-1:0]      r_rd_addr;
    logic [ERR_CNT_W-1:0]   r_err_cnt;
    logic [ADDR_W-1:0]      r_fail_addr;
    logic                   r_fail_vld;

    state_t                 w_nxt_state;
    logic [ADDR_W-1:0]      w_idx;
    logic                   w_mis;
    logic                   w_oor;
    logic                   w_ack;
    logic                   w_err;
    logic                   w_rd_en;
    logic [ERR_CNT_W-1:0]   w_err_cnt;
    logic [ADDR_W-1:0]      w_fail_addr;
    logic                   w_fail_vld;
    logic                   w_chk_mis;

    // A healthy register and its copy are exact complements: XOR is all ones.
    assign w_chk_mis = ((i_scan_reg_rd_data ^ i_scan_reg_rd_chk) != {REG_DW{1'b1}});

    always_comb begin
        w_nxt_state = r_state;
        w_idx       = r_idx;
        w_mis       = r_mis;
        w_oor       = r_oor;
        w_ack       = 1'b0;
        w_err       = 1'b0;
        w_rd_en     = 1'b0;
        w_err_cnt   = r_err_cnt;
        w_fail_addr = r_fail_addr;
        w_fail_vld  = r_fail_vld;

        if (!i_bist_en) begin
            // Leaving the BIST window drops any in-flight check without an ack.
            w_nxt_state = ST_IDLE;
            w_idx       = '0;
            w_mis       = 1'b0;
            w_oor       = 1'b0;
            w_err_cnt   = '0;
            w_fail_addr = '0;
            w_fail_vld  = 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (i_bist_scan_reg_req) begin
                        if (r_idx < LP_IDX_END) begin
                            w_nxt_state = ST_RD;
                            w_rd_en     = 1'b1;
                            w_oor       = 1'b0;
                        end else begin
                            // Run already walked every register: fail fast, no read.
                            w_nxt_state = ST_ACK;
                            w_mis       = 1'b1;
                            w_oor       = 1'b1;
                        end
                    end
                end
                ST_RD: begin
                    w_nxt_state = ST_CHK;
                end
                ST_CHK: begin
                    w_mis       = w_chk_mis;
                    w_nxt_state = ST_ACK;
                end
                ST_ACK: begin
                    w_ack = 1'b1;
                    w_err = r_mis;
                    if (!r_oor) begin
                        if (r_idx != LP_IDX_END) begin
                            w_idx = r_idx + ADDR_W'(1);
                        end
                        if (r_mis) begin
                            if (r_err_cnt != LP_CNT_MAX) begin
                                w_err_cnt = r_err_cnt + ERR_CNT_W'(1);
                            end
                            if (!r_fail_vld) begin
                                w_fail_addr = r_idx;
                                w_fail_vld  = 1'b1;
                            end
                        end
                    end
                    w_nxt_state = ST_WAIT_LOW;
                end
                ST_WAIT_LOW: begin
                    if (!i_bist_scan_reg_req) begin
                        w_nxt_state = ST_IDLE;
                    end
                end
                default: begin
                    w_nxt_state = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_idx       <= '0;
            r_mis       <= 1'b0;
            r_oor       <= 1'b0;
            r_ack       <= 1'b0;
            r_err       <= 1'b0;
            r_rd_en     <= 1'b0;
            r_rd_addr   <= '0;
            r_err_cnt   <= '0;
            r_fail_addr <= '0;
            r_fail_vld  <= 1'b0;
        end else begin
            r_state     <= w_nxt_state;
            r_idx       <= w_idx;
            r_mis       <= w_mis;
            r_oor       <= w_oor;
            r_ack       <= w_ack;
            r_err       <= w_err;
            r_rd_en     <= w_rd_en;
            r_err_cnt   <= w_err_cnt;
            r_fail_addr <= w_fail_addr;
            r_fail_vld  <= w_fail_vld;
            // Address is loaded with the strobe and held until the next read.
            if (w_rd_en) begin
                r_rd_addr <= r_idx;
            end
        end
    end

    assign o_scan_reg_bist_ack = r_ack;
    assign o_scan_reg_bist_err = r_err;
    assign o_scan_reg_rd_en    = r_rd_en;
    assign o_scan_reg_rd_addr  = r_rd_addr;
    assign o_err_cnt           = r_err_cnt;
    assign o_fail_addr         = r_fail_addr;
    assign o_fail_vld          = r_fail_vld;

endmodule
